// File: rtl/dsram_req_ctrl.sv
// ---------------------------------------------------------------------------
// dsram_req_ctrl
//
// Data-SRAM request controller sitting between the EX/MEM stages and the
// SRAM-like data bus (req / addr_ok / data_ok). One transaction is in flight
// at a time. The request is held on the bus until the address handshake,
// then the controller waits for data_ok and hands the response to MEM.
// A WB flush (exception or ertn) cancels the in-flight transaction without
// ever withdrawing a bus request before addr_ok; the matching data_ok is
// still consumed, but no response is produced.
//
// Optional feature macro: DSRAM_RESP_BYPASS_EN
//   defined   : a clean data_ok in WAIT is forwarded to MEM combinationally
//               in the same cycle; it is captured into RESP only if MEM is
//               not ready.
//   undefined : the response always goes through the RESP register, so
//               ms_resp_* are pure register outputs.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   es_req_valid/accept        EX request handshake
//   es_req_wr/size/wstrb/
//   es_req_addr/wdata          EX request payload
//   data_sram_req/wr/size/
//   wstrb/addr/wdata           bus request, driven from hold registers
//   data_sram_addr_ok          bus address handshake
//   data_sram_data_ok/rdata    bus read data / write acknowledge
//   ms_resp_valid/rdata/ready  response to the MEM stage (rdata 0 for stores)
//   wb_exc, wb_ertn            flush requests from WB
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no transaction; accepting from EX unless flushing
// REQ   | data_sram_req high, waiting for addr_ok (never withdrawn)
// WAIT  | address accepted, waiting for data_ok
// RESP  | registered response presented to MEM until ready or flush
// ---------------------------------------------------------------------------
module dsram_req_ctrl (
    input  logic        clk,
    input  logic        reset,

    input  logic        es_req_valid,
    output logic        es_req_accept,
    input  logic        es_req_wr,
    input  logic [1:0]  es_req_size,
    input  logic [3:0]  es_req_wstrb,
    input  logic [31:0] es_req_addr,
    input  logic [31:0] es_req_wdata,

    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,

    output logic        ms_resp_valid,
    output logic [31:0] ms_resp_rdata,
    input  logic        ms_resp_ready,

    input  logic        wb_exc,
    input  logic        wb_ertn
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        discard;
    logic        discard_nxt;
    logic        cap_resp;
    logic        flush;
    logic        req_take;
    logic        data_clean;

    logic        wr_q;
    logic [1:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] resp_rdata_d;

    assign flush = wb_exc | wb_ertn;

    // Accept is also held low during the reset cycle itself.
    assign es_req_accept = (state == S_IDLE) & ~flush & ~reset;
    assign req_take      = es_req_valid & es_req_accept;

    // A data_ok that still belongs to a live (non-cancelled) transaction.
    assign data_clean    = (state == S_WAIT) & data_sram_data_ok & ~discard & ~flush;

    // Stores return zero to MEM.
    assign resp_rdata_d  = wr_q ? 32'h0 : data_sram_rdata;

    always_comb begin
        state_nxt   = state;
        discard_nxt = discard;
        cap_resp    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_take) begin
                    state_nxt   = S_REQ;
                    discard_nxt = 1'b0;
                end
            end
            S_REQ: begin
                if (flush)             discard_nxt = 1'b1;
                if (data_sram_addr_ok) state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                if (flush) discard_nxt = 1'b1;
                if (data_sram_data_ok) begin
                    if (!data_clean) begin
                        state_nxt = S_IDLE;
                    end else begin
`ifdef DSRAM_RESP_BYPASS_EN
                        if (ms_resp_ready) begin
                            state_nxt = S_IDLE;
                        end else begin
                            state_nxt = S_RESP;
                            cap_resp  = 1'b1;
                        end
`else
                        state_nxt = S_RESP;
                        cap_resp  = 1'b1;
`endif
                    end
                end
            end
            S_RESP: begin
                if (ms_resp_ready | flush) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            discard <= 1'b0;
        end else begin
            state   <= state_nxt;
            discard <= discard_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            wstrb_q <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (req_take) begin
            wr_q    <= es_req_wr;
            size_q  <= es_req_size;
            wstrb_q <= es_req_wstrb;
            addr_q  <= es_req_addr;
            wdata_q <= es_req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_rdata_q <= 32'h0;
        end else if (cap_resp) begin
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign data_sram_req   = (state == S_REQ);
    assign data_sram_wr    = wr_q;
    assign data_sram_size  = size_q;
    assign data_sram_wstrb = wstrb_q;
    assign data_sram_addr  = addr_q;
    assign data_sram_wdata = wdata_q;

`ifdef DSRAM_RESP_BYPASS_EN
    assign ms_resp_valid = (state == S_RESP) | data_clean;
    assign ms_resp_rdata = data_clean ? resp_rdata_d : resp_rdata_q;
`else
    assign ms_resp_valid = (state == S_RESP);
    assign ms_resp_rdata = resp_rdata_q;
`endif

endmodule

// File: tb/tb_dsram_req_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dsram_req_ctrl
//
// Directed testbench for dsram_req_ctrl (default build, registered response).
// The bus side is driven by hand, cycle by cycle. Inputs change 1 ns after
// the rising edge and outputs are checked 2 ns after it.
// ---------------------------------------------------------------------------
module tb_dsram_req_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        es_req_valid;
    logic        es_req_accept;
    logic        es_req_wr;
    logic [1:0]  es_req_size;
    logic [3:0]  es_req_wstrb;
    logic [31:0] es_req_addr;
    logic [31:0] es_req_wdata;
    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ms_resp_valid;
    logic [31:0] ms_resp_rdata;
    logic        ms_resp_ready;
    logic        wb_exc;
    logic        wb_ertn;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsram_req_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .es_req_valid      (es_req_valid),
        .es_req_accept     (es_req_accept),
        .es_req_wr         (es_req_wr),
        .es_req_size       (es_req_size),
        .es_req_wstrb      (es_req_wstrb),
        .es_req_addr       (es_req_addr),
        .es_req_wdata      (es_req_wdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_resp_valid     (ms_resp_valid),
        .ms_resp_rdata     (ms_resp_rdata),
        .ms_resp_ready     (ms_resp_ready),
        .wb_exc            (wb_exc),
        .wb_ertn           (wb_ertn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance one cycle; return 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after input changes.
    task automatic settle();
        #1;
    endtask

    // Offer a load in the current cycle and advance; caller is left in REQ.
    task automatic issue_load(input logic [31:0] addr);
        es_req_valid = 1'b1;
        es_req_wr    = 1'b0;
        es_req_size  = 2'd2;
        es_req_wstrb = 4'h0;
        es_req_addr  = addr;
        es_req_wdata = 32'h0;
        tick();
        es_req_valid = 1'b0;
    endtask

    initial begin
        reset             = 1'b1;
        es_req_valid      = 1'b0;
        es_req_wr         = 1'b0;
        es_req_size       = 2'd0;
        es_req_wstrb      = 4'h0;
        es_req_addr       = 32'h0;
        es_req_wdata      = 32'h0;
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ms_resp_ready     = 1'b0;
        wb_exc            = 1'b0;
        wb_ertn           = 1'b0;

        // ---------------- reset state ----------------
        tick();
        es_req_valid = 1'b1;
        settle();
        check("rst_req",    {31'h0, data_sram_req}, 32'd0);
        check("rst_valid",  {31'h0, ms_resp_valid}, 32'd0);
        check("rst_accept", {31'h0, es_req_accept}, 32'd0);
        check("rst_rdata",  ms_resp_rdata, 32'h0);
        check("rst_addr",   data_sram_addr, 32'h0);
        check("rst_wdata",  data_sram_wdata, 32'h0);
        es_req_valid = 1'b0;
        reset = 1'b0;
        tick();

        // ---------------- load word, registered response ----------------
        es_req_valid = 1'b1;
        es_req_wr    = 1'b0;
        es_req_size  = 2'd2;
        es_req_addr  = 32'h1c000100;
        settle();
        check("ld_accept", {31'h0, es_req_accept}, 32'd1);
        tick();                                  // T+1
        es_req_valid = 1'b0;
        settle();
        check("ld_req_t1", {31'h0, data_sram_req}, 32'd1);
        check("ld_addr",   data_sram_addr, 32'h1c000100);
        check("ld_wr",     {31'h0, data_sram_wr}, 32'd0);
        check("ld_size",   {30'h0, data_sram_size}, 32'd2);
        tick();                                  // T+2
        data_sram_addr_ok = 1'b1;
        settle();
        check("ld_req_t2", {31'h0, data_sram_req}, 32'd1);
        tick();                                  // T+3, WAIT
        data_sram_addr_ok = 1'b0;
        settle();
        check("ld_req_t3", {31'h0, data_sram_req}, 32'd0);
        tick();                                  // T+4
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hdeadbeef;
        settle();
        check("ld_valid_t4", {31'h0, ms_resp_valid}, 32'd0);
        tick();                                  // T+5, RESP
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        ms_resp_ready     = 1'b1;
        settle();
        check("ld_valid_t5",  {31'h0, ms_resp_valid}, 32'd1);
        check("ld_rdata",     ms_resp_rdata, 32'hdeadbeef);
        check("ld_accept_t5", {31'h0, es_req_accept}, 32'd0);
        tick();                                  // IDLE
        ms_resp_ready = 1'b0;
        settle();
        check("ld_valid_t6",  {31'h0, ms_resp_valid}, 32'd0);
        check("ld_accept_t6", {31'h0, es_req_accept}, 32'd1);

        // ---------------- store byte, addr_ok held off ----------------
        es_req_valid = 1'b1;
        es_req_wr    = 1'b1;
        es_req_size  = 2'd0;
        es_req_wstrb = 4'b0100;
        es_req_addr  = 32'h1c000202;
        es_req_wdata = 32'h00ab0000;
        tick();
        es_req_valid = 1'b0;
        es_req_wr    = 1'b0;
        es_req_size  = 2'd3;
        es_req_wstrb = 4'hf;
        es_req_addr  = 32'hffffffff;
        es_req_wdata = 32'h12121212;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("st_req",   {31'h0, data_sram_req}, 32'd1);
            check("st_addr",  data_sram_addr, 32'h1c000202);
            check("st_wdata", data_sram_wdata, 32'h00ab0000);
            check("st_wstrb", {28'h0, data_sram_wstrb}, 32'h4);
            check("st_wr",    {31'h0, data_sram_wr}, 32'd1);
            check("st_size",  {30'h0, data_sram_size}, 32'd0);
            tick();
        end
        data_sram_addr_ok = 1'b1;
        settle();
        check("st_req_ok", {31'h0, data_sram_req}, 32'd1);
        tick();
        data_sram_addr_ok = 1'b0;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h87654321;
        tick();
        data_sram_data_ok = 1'b0;
        ms_resp_ready     = 1'b1;
        settle();
        check("st_valid", {31'h0, ms_resp_valid}, 32'd1);
        check("st_rdata", ms_resp_rdata, 32'h0);
        tick();
        ms_resp_ready = 1'b0;
        settle();
        check("st_done", {31'h0, ms_resp_valid}, 32'd0);

        // ---------------- flush during REQ ----------------
        issue_load(32'h00000100);
        wb_exc = 1'b1;
        settle();
        check("fr_req_flush", {31'h0, data_sram_req}, 32'd1);
        check("fr_accept",    {31'h0, es_req_accept}, 32'd0);
        tick();
        wb_exc = 1'b0;
        settle();
        check("fr_req_hold", {31'h0, data_sram_req}, 32'd1);
        tick();
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hcafef00d;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        check("fr_no_resp", {31'h0, ms_resp_valid}, 32'd0);
        check("fr_idle",    {31'h0, es_req_accept}, 32'd1);
        issue_load(32'h00000200);
        settle();
        check("fr_next_req",  {31'h0, data_sram_req}, 32'd1);
        check("fr_next_addr", data_sram_addr, 32'h00000200);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11223344;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        check("fr_next_valid", {31'h0, ms_resp_valid}, 32'd1);
        check("fr_next_rdata", ms_resp_rdata, 32'h11223344);
        ms_resp_ready = 1'b1;
        tick();
        ms_resp_ready = 1'b0;

        // ---------------- wb_exc coincident with data_ok ----------------
        issue_load(32'h00000300);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h00000055;
        wb_exc            = 1'b1;
        tick();
        data_sram_data_ok = 1'b0;
        wb_exc            = 1'b0;
        settle();
        check("ex_no_resp", {31'h0, ms_resp_valid}, 32'd0);
        check("ex_idle",    {31'h0, es_req_accept}, 32'd1);
        check("ex_no_req",  {31'h0, data_sram_req}, 32'd0);

        // ---------------- flush in IDLE with a pending request ----------------
        es_req_valid = 1'b1;
        es_req_addr  = 32'h00000400;
        wb_ertn      = 1'b1;
        settle();
        check("fi_accept", {31'h0, es_req_accept}, 32'd0);
        tick();
        wb_ertn      = 1'b0;
        es_req_valid = 1'b0;
        settle();
        check("fi_no_req", {31'h0, data_sram_req}, 32'd0);

        // ---------------- MEM back-pressure in RESP ----------------
        issue_load(32'h00000500);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'ha5a5a5a5;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        es_req_valid      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_valid",  {31'h0, ms_resp_valid}, 32'd1);
            check("bp_rdata",  ms_resp_rdata, 32'ha5a5a5a5);
            check("bp_accept", {31'h0, es_req_accept}, 32'd0);
            tick();
        end
        es_req_valid  = 1'b0;
        ms_resp_ready = 1'b1;
        settle();
        check("bp_valid_rdy", {31'h0, ms_resp_valid}, 32'd1);
        tick();
        ms_resp_ready = 1'b0;
        settle();
        check("bp_consumed", {31'h0, ms_resp_valid}, 32'd0);

        // ---------------- reset during WAIT ----------------
        issue_load(32'h00000600);
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        es_req_valid = 1'b1;
        es_req_addr  = 32'h00000700;
        settle();
        check("rw_req",    {31'h0, data_sram_req}, 32'd0);
        check("rw_valid",  {31'h0, ms_resp_valid}, 32'd0);
        check("rw_accept", {31'h0, es_req_accept}, 32'd1);
        check("rw_addr",   data_sram_addr, 32'h0);
        tick();
        es_req_valid = 1'b0;
        data_sram_addr_ok = 1'b1;
        settle();
        check("rw_new_addr", data_sram_addr, 32'h00000700);
        tick();
        data_sram_addr_ok = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0badf00d;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        check("rw_new_rdata", ms_resp_rdata, 32'h0badf00d);
        ms_resp_ready = 1'b1;
        tick();
        ms_resp_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
